// File: rtl/mdu_hilo_unit.sv
// Multiply/divide unit with architectural HI/LO registers and a hazard stall request.
// Optional build macro MDU_DIV_EN adds the iterative restoring divider (DIV/DIVU).
module mdu_hilo_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] srca_i,
  input  logic [WIDTH-1:0] srcb_i,
  input  logic             rdhilo_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_STAGES - 1);
  localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  function automatic logic [WIDTH-1:0] applySign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] applySignWide(input logic [2*WIDTH-1:0] v,
                                                       input logic neg);
    return neg ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  state_t           state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             isMul, isDiv, isMthi, isMtlo, isSigned, validOp, accept;
  logic             writeMul, writeDiv;

  logic [WIDTH-1:0]   magA_p0, magB_p0;
  logic               negRes_p0;
  logic [2*WIDTH-1:0] mulProd;

  always_comb begin
    isMul  = (op_i == OP_MULT) || (op_i == OP_MULTU);
`ifdef MDU_DIV_EN
    isDiv  = (op_i == OP_DIV) || (op_i == OP_DIVU);
`else
    isDiv  = 1'b0;
`endif
    isMthi   = (op_i == OP_MTHI);
    isMtlo   = (op_i == OP_MTLO);
    isSigned = ~op_i[0];
    validOp  = isMul | isDiv | isMthi | isMtlo;
  end

  assign busy_o  = (state != IDLE);
  assign stall_o = busy_o & (start_i | rdhilo_i);
  assign accept  = start_i & ~busy_o & ~flush_i & validOp;

  // A flush always wins, including on the cycle that would otherwise write HI/LO.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    writeMul  = 1'b0;
    writeDiv  = 1'b0;
    case (state)
      IDLE: begin
        if (accept && isMul) begin
          stateNext = MUL;
          cntNext   = MUL_CNT_INIT;
        end else if (accept && isDiv) begin
          stateNext = DIV;
          cntNext   = DIV_CNT_INIT;
        end
      end
      MUL: begin
        if (flush_i) begin
          stateNext = IDLE;
        end else if (cnt == '0) begin
          stateNext = IDLE;
          writeMul  = 1'b1;
        end else begin
          cntNext = cnt - CNT_W'(1);
        end
      end
`ifdef MDU_DIV_EN
      DIV: begin
        if (flush_i) begin
          stateNext = IDLE;
        end else if (cnt == '0) begin
          stateNext = IDLE;
          writeDiv  = 1'b1;
        end else begin
          cntNext = cnt - CNT_W'(1);
        end
      end
`endif
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

`ifdef MDU_DIV_EN
  logic [WIDTH-1:0] rawA_p0, rem_p0, quo_p0, remNext, quoNext;
  logic             divZero_p0, negRem_p0;
  logic [WIDTH:0]   remShift, remTrial;

  // One restoring step: shift in the next dividend bit, keep the trial only if non-negative.
  always_comb begin
    remShift = {rem_p0, quo_p0[WIDTH-1]};
    remTrial = remShift - {1'b0, magB_p0};
    if (!remTrial[WIDTH]) begin
      remNext = remTrial[WIDTH-1:0];
      quoNext = {quo_p0[WIDTH-2:0], 1'b1};
    end else begin
      remNext = remShift[WIDTH-1:0];
      quoNext = {quo_p0[WIDTH-2:0], 1'b0};
    end
  end
`endif

  // Stage p0: operands captured as magnitudes at accept; later source changes are ignored.
  always_ff @(posedge clk) begin
    if (accept && (isMul || isDiv)) begin
      magA_p0   <= applySign(srca_i, isSigned & srca_i[WIDTH-1]);
      magB_p0   <= applySign(srcb_i, isSigned & srcb_i[WIDTH-1]);
      negRes_p0 <= isSigned & (srca_i[WIDTH-1] ^ srcb_i[WIDTH-1]);
`ifdef MDU_DIV_EN
      rawA_p0    <= srca_i;
      divZero_p0 <= (srcb_i == '0);
      negRem_p0  <= isSigned & srca_i[WIDTH-1];
      rem_p0     <= '0;
      quo_p0     <= applySign(srca_i, isSigned & srca_i[WIDTH-1]);
`endif
    end
`ifdef MDU_DIV_EN
    else if (state == DIV) begin
      rem_p0 <= remNext;
      quo_p0 <= quoNext;
    end
`endif
  end

  assign mulProd = (2*WIDTH)'(magA_p0) * (2*WIDTH)'(magB_p0);

  // Architectural HI/LO: result write, or direct MTHI/MTLO move when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_o   <= '0;
      lo_o   <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= writeMul | writeDiv;
      if (writeMul) begin
        {hi_o, lo_o} <= applySignWide(mulProd, negRes_p0);
      end
`ifdef MDU_DIV_EN
      else if (writeDiv) begin
        if (divZero_p0) begin
          lo_o <= '1;
          hi_o <= rawA_p0;
        end else begin
          lo_o <= applySign(quoNext, negRes_p0);
          hi_o <= applySign(remNext, negRem_p0);
        end
      end
`endif
      else if (accept && isMthi) begin
        hi_o <= srca_i;
      end else if (accept && isMtlo) begin
        lo_o <= srca_i;
      end
    end
  end

endmodule
